// File: rtl/stg_wb.sv
// ---------------------------------------------------------------------------
// stg_wb -- write-back stage, directly downstream of stg_mo.
//
// The stage register captures stg_mo's trace fields (pc/instr/opc), the
// GP/SR/AR targets with their enables, and the three result buses. The
// captured entry drives the GP, SR and AR register-file write ports one
// cycle after stg_mo presents it.
//
// The block also provides:
//   - a retired-instruction counter (non-bubble captures, wraps silently);
//   - a debug halt/resume FSM (RUN -> DRAIN -> HALTED -> RUN) that raises
//     ow_stall_up so that upstream holds its outputs while the stage is
//     frozen.
//
// Optional feature (define WB_FWD_EN): forwarding buses ow_fwd_{gp,sr,ar}_*
// mirror the write currently on the register-file ports, so that the EX
// stage can bypass without waiting for the register-file write.
//
// Ports:
//   iw_clk, iw_rst_n          clock, synchronous active-low reset
//   iw_pc/instr/opc           trace fields from stg_mo (OPC_NOP = bubble)
//   iw_tgt_{gp,sr,ar}[_we]    write targets and enables
//   iw_result                 GP write data
//   iw_sr_result/ar_result    SR / AR write data
//   iw_flush                  turn the next captured entry into a bubble
//   iw_halt_req, iw_resume    debug halt request (level), resume (pulse)
//   ow_{gp,sr,ar}_{we,addr,wdata}  register-file write ports
//   ow_pc/instr/opc           registered trace copies
//   ow_retired                retired-instruction count
//   ow_stall_up               upstream must hold its outputs
//   ow_halted                 FSM is in HALTED
// ---------------------------------------------------------------------------

`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef HBIT_OPC
`define HBIT_OPC 5
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 1
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 1
`endif
`ifndef OPC_NOP
`define OPC_NOP 6'h00
`endif
`ifndef OPC_LDur
`define OPC_LDur 6'h01
`endif

module stg_wb #(
  parameter int CNT_W       = 48,
  parameter bit HALT_ON_RST = 1'b0
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst_n,
  input  logic [`HBIT_ADDR:0]     iw_pc,
  input  logic [`HBIT_DATA:0]     iw_instr,
  input  logic [`HBIT_OPC:0]      iw_opc,
  input  logic [`HBIT_TGT_GP:0]   iw_tgt_gp,
  input  logic                    iw_tgt_gp_we,
  input  logic [`HBIT_TGT_SR:0]   iw_tgt_sr,
  input  logic                    iw_tgt_sr_we,
  input  logic [`HBIT_TGT_AR:0]   iw_tgt_ar,
  input  logic                    iw_tgt_ar_we,
  input  logic [`HBIT_DATA:0]     iw_result,
  input  logic [`HBIT_ADDR:0]     iw_sr_result,
  input  logic [`HBIT_ADDR:0]     iw_ar_result,
  input  logic                    iw_flush,
  input  logic                    iw_halt_req,
  input  logic                    iw_resume,
  output logic                    ow_gp_we,
  output logic [`HBIT_TGT_GP:0]   ow_gp_addr,
  output logic [`HBIT_DATA:0]     ow_gp_wdata,
  output logic                    ow_sr_we,
  output logic [`HBIT_TGT_SR:0]   ow_sr_addr,
  output logic [`HBIT_ADDR:0]     ow_sr_wdata,
  output logic                    ow_ar_we,
  output logic [`HBIT_TGT_AR:0]   ow_ar_addr,
  output logic [`HBIT_ADDR:0]     ow_ar_wdata,
  output logic [`HBIT_ADDR:0]     ow_pc,
  output logic [`HBIT_DATA:0]     ow_instr,
  output logic [`HBIT_OPC:0]      ow_opc,
  output logic [CNT_W-1:0]        ow_retired,
  output logic                    ow_stall_up,
  output logic                    ow_halted
`ifdef WB_FWD_EN
  ,
  output logic                    ow_fwd_gp_vld,
  output logic [`HBIT_TGT_GP:0]   ow_fwd_gp,
  output logic [`HBIT_DATA:0]     ow_fwd_gp_data,
  output logic                    ow_fwd_sr_vld,
  output logic [`HBIT_TGT_SR:0]   ow_fwd_sr,
  output logic [`HBIT_ADDR:0]     ow_fwd_sr_data,
  output logic                    ow_fwd_ar_vld,
  output logic [`HBIT_TGT_AR:0]   ow_fwd_ar,
  output logic [`HBIT_ADDR:0]     ow_fwd_ar_data
`endif
);

  // One stage-register entry.
  typedef struct packed {
    logic [`HBIT_ADDR:0]   pc;
    logic [`HBIT_DATA:0]   instr;
    logic [`HBIT_OPC:0]    opc;
    logic [`HBIT_TGT_GP:0] gp;
    logic                  gp_we;
    logic [`HBIT_TGT_SR:0] sr;
    logic                  sr_we;
    logic [`HBIT_TGT_AR:0] ar;
    logic                  ar_we;
    logic [`HBIT_DATA:0]   result;
    logic [`HBIT_ADDR:0]   sr_result;
    logic [`HBIT_ADDR:0]   ar_result;
  } wb_ent_t;

  // FSM encoding.
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_RST   = HALT_ON_RST ? S_HALT : S_RUN;

  logic [1:0]       state_q, state_d;
  wb_ent_t          ent_q, ent_d, ent_rst;
  logic [CNT_W-1:0] retired_q;
  logic             capture;
  logic             bubble;

  // ---------------------------------------------------------------------
  // Halt/resume FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (iw_halt_req) state_d = S_DRAIN;
      // The drain cycle lets the entry captured on the halt edge finish
      // its write; the next edge always parks the stage.
      S_DRAIN: state_d = S_HALT;
      // Halt request dominates a simultaneous resume.
      S_HALT:  if (iw_resume && !iw_halt_req) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Only RUN captures. The resume edge is spent in HALTED, so nothing is
  // captured on it; capture restarts on the following edge, when upstream
  // has already seen stall drop.
  assign capture = (state_q == S_RUN);

  // ---------------------------------------------------------------------
  // Next entry
  // ---------------------------------------------------------------------
  assign bubble = iw_flush || (iw_opc == `OPC_NOP);

  always_comb begin
    ent_d           = '0;
    ent_d.pc        = iw_pc;
    ent_d.instr     = iw_instr;
    ent_d.opc       = bubble ? `OPC_NOP : iw_opc;
    ent_d.gp        = iw_tgt_gp;
    ent_d.gp_we     = iw_tgt_gp_we && !bubble;
    ent_d.sr        = iw_tgt_sr;
    ent_d.sr_we     = iw_tgt_sr_we && !bubble;
    ent_d.ar        = iw_tgt_ar;
    ent_d.ar_we     = iw_tgt_ar_we && !bubble;
    ent_d.result    = iw_result;
    ent_d.sr_result = iw_sr_result;
    ent_d.ar_result = iw_ar_result;
  end

  always_comb begin
    ent_rst     = '0;
    ent_rst.opc = `OPC_NOP;
  end

  // ---------------------------------------------------------------------
  // Stage register, retire counter, FSM state
  // ---------------------------------------------------------------------
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q   <= S_RST;
      ent_q     <= ent_rst;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        ent_q <= ent_d;
        if (!bubble) retired_q <= retired_q + CNT_W'(1);
      end else if (state_q == S_DRAIN) begin
        // Entering HALTED: drop the enables so the drained entry is not
        // written a second time, neither while parked nor right after
        // resume (the resume edge captures nothing).
        ent_q.gp_we <= 1'b0;
        ent_q.sr_we <= 1'b0;
        ent_q.ar_we <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all data comes straight from the stage register
  // ---------------------------------------------------------------------
  assign ow_gp_we    = ent_q.gp_we;
  assign ow_gp_addr  = ent_q.gp;
  assign ow_gp_wdata = ent_q.result;
  assign ow_sr_we    = ent_q.sr_we;
  assign ow_sr_addr  = ent_q.sr;
  assign ow_sr_wdata = ent_q.sr_result;
  assign ow_ar_we    = ent_q.ar_we;
  assign ow_ar_addr  = ent_q.ar;
  assign ow_ar_wdata = ent_q.ar_result;
  assign ow_pc       = ent_q.pc;
  assign ow_instr    = ent_q.instr;
  assign ow_opc      = ent_q.opc;
  assign ow_retired  = retired_q;
  assign ow_stall_up = (state_q != S_RUN);
  assign ow_halted   = (state_q == S_HALT);

`ifdef WB_FWD_EN
  assign ow_fwd_gp_vld  = ent_q.gp_we;
  assign ow_fwd_gp      = ent_q.gp;
  assign ow_fwd_gp_data = ent_q.result;
  assign ow_fwd_sr_vld  = ent_q.sr_we;
  assign ow_fwd_sr      = ent_q.sr;
  assign ow_fwd_sr_data = ent_q.sr_result;
  assign ow_fwd_ar_vld  = ent_q.ar_we;
  assign ow_fwd_ar      = ent_q.ar;
  assign ow_fwd_ar_data = ent_q.ar_result;
`endif

endmodule

// File: tb/tb_stg_wb.sv
// Directed bench for stg_wb: GP writes are scored through a queue filled
// when an accepted entry is driven and drained by a negedge monitor.

`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef HBIT_OPC
`define HBIT_OPC 5
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 1
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 1
`endif
`ifndef OPC_NOP
`define OPC_NOP 6'h00
`endif
`ifndef OPC_LDur
`define OPC_LDur 6'h01
`endif

module tb_stg_wb;
  localparam int CNT_W = 48;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [`HBIT_ADDR:0]   pc;
  logic [`HBIT_DATA:0]   instr;
  logic [`HBIT_OPC:0]    opc;
  logic [`HBIT_TGT_GP:0] tgt_gp;
  logic                  tgt_gp_we;
  logic [`HBIT_TGT_SR:0] tgt_sr;
  logic                  tgt_sr_we;
  logic [`HBIT_TGT_AR:0] tgt_ar;
  logic                  tgt_ar_we;
  logic [`HBIT_DATA:0]   result;
  logic [`HBIT_ADDR:0]   sr_result, ar_result;
  logic                  flush, halt_req, resume;

  logic                  ow_gp_we, ow_sr_we, ow_ar_we;
  logic [`HBIT_TGT_GP:0] ow_gp_addr;
  logic [`HBIT_DATA:0]   ow_gp_wdata;
  logic [`HBIT_TGT_SR:0] ow_sr_addr;
  logic [`HBIT_ADDR:0]   ow_sr_wdata;
  logic [`HBIT_TGT_AR:0] ow_ar_addr;
  logic [`HBIT_ADDR:0]   ow_ar_wdata;
  logic [`HBIT_ADDR:0]   ow_pc;
  logic [`HBIT_DATA:0]   ow_instr;
  logic [`HBIT_OPC:0]    ow_opc;
  logic [CNT_W-1:0]      ow_retired;
  logic                  ow_stall_up, ow_halted;

  int errors = 0;
  int checks = 0;
  logic [27:0] sb[$];   // {gp addr, gp data}

  stg_wb #(.CNT_W(CNT_W), .HALT_ON_RST(1'b0)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n),
    .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
    .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(tgt_gp_we),
    .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(tgt_sr_we),
    .iw_tgt_ar(tgt_ar), .iw_tgt_ar_we(tgt_ar_we),
    .iw_result(result), .iw_sr_result(sr_result), .iw_ar_result(ar_result),
    .iw_flush(flush), .iw_halt_req(halt_req), .iw_resume(resume),
    .ow_gp_we(ow_gp_we), .ow_gp_addr(ow_gp_addr), .ow_gp_wdata(ow_gp_wdata),
    .ow_sr_we(ow_sr_we), .ow_sr_addr(ow_sr_addr), .ow_sr_wdata(ow_sr_wdata),
    .ow_ar_we(ow_ar_we), .ow_ar_addr(ow_ar_addr), .ow_ar_wdata(ow_ar_wdata),
    .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
    .ow_retired(ow_retired), .ow_stall_up(ow_stall_up), .ow_halted(ow_halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data inputs to a harmless bubble; debug controls and reset untouched.
  task automatic idle();
    pc = '0; instr = '0; opc = `OPC_NOP; flush = 1'b0;
    tgt_gp = '0; tgt_gp_we = 1'b0; tgt_sr = '0; tgt_sr_we = 1'b0;
    tgt_ar = '0; tgt_ar_we = 1'b0;
    result = '0; sr_result = '0; ar_result = '0;
  endtask

  task automatic drive_gp(input logic [3:0] a, input logic [23:0] d);
    idle();
    opc = `OPC_LDur; tgt_gp = a; tgt_gp_we = 1'b1; result = d;
    pc = {24'h0, d}; instr = d;
  endtask

  // Scoreboard monitor: every GP write must match the oldest expectation.
  always @(negedge clk) begin
    if (ow_gp_we === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL gp_unexpected: observed addr=%0h data=%0h expected no write",
               ow_gp_addr, ow_gp_wdata);
      end
      if (sb.size() != 0) check("gp_sb", {36'h0, ow_gp_addr, ow_gp_wdata}, {36'h0, sb.pop_front()});
    end
  end

  initial begin
    int idx;
    logic [23:0] items [4];
    items[0] = 24'h100001; items[1] = 24'h200002;
    items[2] = 24'h300003; items[3] = 24'h400004;

    // Reset held two cycles with a would-be write on the inputs.
    idle(); halt_req = 1'b0; resume = 1'b0; rst_n = 1'b0;
    opc = `OPC_LDur; tgt_gp = 4'd7; tgt_gp_we = 1'b1; result = 24'hFFFFFF;
    repeat (2) @(negedge clk);
    check("rst_gp_we", ow_gp_we, 0);
    check("rst_sr_we", ow_sr_we, 0);
    check("rst_ar_we", ow_ar_we, 0);
    check("rst_retired", ow_retired, 0);
    check("rst_halted", ow_halted, 0);
    check("rst_stall", ow_stall_up, 0);
    check("rst_opc", ow_opc, `OPC_NOP);
    check("rst_gp_addr", ow_gp_addr, 0);
    idle(); rst_n = 1'b1;
    @(negedge clk);

    // Single GP write, then a bubble.
    drive_gp(4'd3, 24'hA1B2C3); sb.push_back({4'd3, 24'hA1B2C3});
    @(negedge clk);
    check("gp_we", ow_gp_we, 1);
    check("gp_addr", ow_gp_addr, 3);
    check("gp_wdata", ow_gp_wdata, 24'hA1B2C3);
    check("gp_pc", ow_pc, 48'hA1B2C3);
    check("gp_opc", ow_opc, `OPC_LDur);
    idle();
    @(negedge clk);
    check("gp_we_nop", ow_gp_we, 0);
    check("retired_1", ow_retired, 1);

    // All three ports from one entry.
    drive_gp(4'd5, 24'h5A5A5A); sb.push_back({4'd5, 24'h5A5A5A});
    tgt_sr = 2'd2; tgt_sr_we = 1'b1; sr_result = 48'h123456789ABC;
    tgt_ar = 2'd1; tgt_ar_we = 1'b1; ar_result = 48'h000000000040;
    @(negedge clk);
    check("cmb_gp_we", ow_gp_we, 1);
    check("cmb_sr_we", ow_sr_we, 1);
    check("cmb_sr_addr", ow_sr_addr, 2);
    check("cmb_sr_wdata", ow_sr_wdata, 48'h123456789ABC);
    check("cmb_ar_we", ow_ar_we, 1);
    check("cmb_ar_addr", ow_ar_addr, 1);
    check("cmb_ar_wdata", ow_ar_wdata, 48'h40);
    check("cmb_retired", ow_retired, 2);
    idle();
    @(negedge clk);
    check("cmb_sr_off", ow_sr_we, 0);

    // Flush and NOP-opcode bubbles: no write, no retire.
    drive_gp(4'd6, 24'h111111); flush = 1'b1;
    @(negedge clk);
    check("flush_gp_we", ow_gp_we, 0);
    check("flush_opc", ow_opc, `OPC_NOP);
    check("flush_retired", ow_retired, 2);
    drive_gp(4'd6, 24'h222222); opc = `OPC_NOP;
    @(negedge clk);
    check("nop_gp_we", ow_gp_we, 0);
    check("nop_retired", ow_retired, 2);
    idle();

    // Fresh reset so the halt stream's retire count starts from zero.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_retired", ow_retired, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Halt during a 4-write stream; driver honours ow_stall_up and presents
    // junk writes while stalled so any illegal capture would show.
    idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc == 1) halt_req = 1'b1;
      if (cyc == 8) begin halt_req = 1'b0; resume = 1'b1; end
      else resume = 1'b0;
      if (!ow_stall_up) begin
        if (idx < 4) begin
          drive_gp(4'(8 + idx), items[idx]);
          sb.push_back({4'(8 + idx), items[idx]});
          idx++;
        end else idle();
      end else begin
        drive_gp(4'hF, 24'hDEAD00);
      end
      @(negedge clk);
      if (cyc == 1) begin
        check("drain_stall", ow_stall_up, 1);
        check("drain_halted", ow_halted, 0);
        check("drain_gp_we", ow_gp_we, 1);
      end
      if (cyc >= 2 && cyc <= 6) begin
        check("halt_halted", ow_halted, 1);
        check("halt_gp_we", ow_gp_we, 0);
        check("halt_retired", ow_retired, 2);
      end
      if (cyc == 8) begin
        check("resume_halted", ow_halted, 0);
        check("resume_stall", ow_stall_up, 0);
        check("resume_gp_we", ow_gp_we, 0);
      end
    end
    idle();
    check("stream_sent", idx, 4);
    check("stream_sb_empty", sb.size(), 0);
    check("stream_retired", ow_retired, 4);

    // Reset while halted wins.
    halt_req = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_halted", ow_halted, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_halted", ow_halted, 0);
    check("mid_rst_stall", ow_stall_up, 0);
    rst_n = 1'b1; halt_req = 1'b0;
    @(negedge clk);

    // Counter wrap from all-ones.
    dut.retired_q <= '1;
    @(negedge clk);
    drive_gp(4'd2, 24'h000ABC); sb.push_back({4'd2, 24'h000ABC});
    @(negedge clk);
    check("wrap_retired", ow_retired, 0);
    check("wrap_gp_we", ow_gp_we, 1);
    idle();
    @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stg_wb.md
Name: stg_wb

Overview:
- Write-back stage, directly downstream of stg_mo.
- Consumes stg_mo's pc/instr/opc, GP/SR/AR targets and results through a stage register.
- Drives the GP, SR and AR register-file write ports one cycle later.
- Also provides a retired-instruction counter and a debug halt/resume FSM that back-pressures upstream.

Parameters:
- CNT_W, 48, width of the retired-instruction counter; wraps modulo 2^CNT_W.
- HALT_ON_RST, 0, when 1 the FSM leaves reset in HALTED instead of RUN.

Ports:
- iw_clk  in  1  clock, all state updates on rising edge.
- iw_rst_n  in  1  synchronous, active-low reset.
- iw_pc  in  `HBIT_ADDR+1  pc from stg_mo.
- iw_instr  in  `HBIT_DATA+1  instruction word from stg_mo.
- iw_opc  in  `HBIT_OPC+1  opcode from stg_mo; `OPC_NOP marks a bubble.
- iw_tgt_gp / iw_tgt_gp_we  in  `HBIT_TGT_GP+1 / 1  GP target and write enable.
- iw_tgt_sr / iw_tgt_sr_we  in  `HBIT_TGT_SR+1 / 1  SR target and write enable.
- iw_tgt_ar / iw_tgt_ar_we  in  `HBIT_TGT_AR+1 / 1  AR target and write enable.
- iw_result  in  `HBIT_DATA+1  GP write data.
- iw_sr_result  in  `HBIT_ADDR+1  SR write data.
- iw_ar_result  in  `HBIT_ADDR+1  AR write data.
- iw_flush  in  1  replace the next captured entry with a bubble.
- iw_halt_req  in  1  debug halt request (level).
- iw_resume  in  1  debug resume pulse.
- ow_gp_we, ow_gp_addr, ow_gp_wdata  out  1, `HBIT_TGT_GP+1, `HBIT_DATA+1  GP write port.
- ow_sr_we, ow_sr_addr, ow_sr_wdata  out  1, `HBIT_TGT_SR+1, `HBIT_ADDR+1  SR write port.
- ow_ar_we, ow_ar_addr, ow_ar_wdata  out  1, `HBIT_TGT_AR+1, `HBIT_ADDR+1  AR write port.
- ow_pc, ow_instr, ow_opc  out  as inputs  registered copies for trace.
- ow_retired  out  CNT_W  count of retired non-bubble entries.
- ow_stall_up  out  1  upstream must hold its outputs.
- ow_halted  out  1  FSM is in HALTED.

Behaviour:
- Reset (iw_rst_n=0 at a rising edge):
  - All *_we = 0; addrs, wdata, ow_pc, ow_instr = 0; ow_opc = `OPC_NOP.
  - ow_retired = 0; ow_stall_up = 0.
  - FSM = RUN (HALTED if HALT_ON_RST=1); ow_halted reflects the state.
  - Reset mid-halt or mid-flush wins over everything.
- Stage register, capture: in RUN, every edge captures all inputs. Write ports reflect the captured entry, so latency is 1 cycle from stg_mo output to ow_*_we.
- Stage register, bubble: an entry is a bubble when iw_flush=1 at capture or iw_opc==`OPC_NOP. A bubble forces all three we=0 and ow_opc=`OPC_NOP; data/addr fields still capture (don't-care).
- Independent targets: GP/SR/AR enables are independent, so one entry may write any combination of the three in the same cycle.
- Retire counter: ow_retired increments by 1 on each edge that captures a non-bubble entry. Wraps from all-ones to 0 with no flag.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when iw_halt_req=1.
  - DRAIN lasts exactly 1 cycle: the entry captured on the transition edge is written back normally, and nothing new is captured.
  - DRAIN -> HALTED unconditionally.
  - HALTED -> RUN when iw_resume=1 and iw_halt_req=0; otherwise stay in HALTED. iw_halt_req has priority over iw_resume.
- Outputs in DRAIN and HALTED:
  - ow_stall_up = 1 combinationally from state.
  - Stage register frozen; all we forced 0 from the first HALTED cycle.
  - ow_retired frozen.
  - iw_flush is ignored while frozen.
- Resume: on the edge entering RUN nothing is captured. Capture restarts on the next edge, and upstream sees ow_stall_up=0 in the cycle after resume.
- ow_halted = 1 only in HALTED.
- No combinational path from iw_* data to ow_* data, except through the optional forwarding bus.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds ow_fwd_gp_vld/ow_fwd_gp/ow_fwd_gp_data, equal to the currently captured GP write (vld = ow_gp_we). Same triple for SR and AR, for EX-stage bypassing without waiting for the register-file write.
- Undefined: these ports and their logic do not exist; the interface is otherwise identical.

Test Plan:
- Reset: hold iw_rst_n=0 two cycles with iw_opc=`OPC_LDur, iw_tgt_gp_we=1 -> all we=0, ow_retired=0, ow_halted=0, ow_opc=`OPC_NOP.
- GP write: drive tgt_gp=3, we=1, result=24'hA1B2C3 for one cycle -> next cycle ow_gp_we=1, addr=3, wdata=A1B2C3; following cycle with NOP -> ow_gp_we=0; ow_retired=1.
- Combined write: one entry with gp/sr/ar all enabled (sr=48'h123456789ABC, ar=48'h000000000040) -> all three ports assert in the same cycle; ow_retired increments by exactly 1.
- Flush: iw_flush=1 with a valid GP write -> no write, ow_retired unchanged.
- Halt/resume: assert iw_halt_req during a stream of 4 GP writes.
  - Required: the in-flight entry is written back, ow_stall_up=1, ow_halted=1 after 2 cycles, and no further writes during 5 held cycles.
  - Then drop iw_halt_req and pulse iw_resume: the remaining writes complete in order and ow_retired ends at 4.
- Wrap: force ow_retired to all-ones via hierarchical deposit, retire one entry -> ow_retired=0.
